// File: rtl/imm_gen_stage_pkg.sv
// Shared constants for the registered immediate generator.
// IMM_GEN_ONEHOT_CHK_EN enables the one-hot type check.
package imm_gen_stage_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int IMM_TYPE_W   = 7;

  localparam int T_B  = 0;
  localparam int T_I  = 1;
  localparam int T_S  = 2;
  localparam int T_U  = 3;
  localparam int T_J  = 4;
  localparam int T_Z  = 5;
  localparam int T_SH = 6;

  localparam int F_SIGN  = 31;
  localparam int F_RS1_H = 19;
  localparam int F_RS1_L = 15;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate former: AND-OR mux over the
// seven one-hot classes, built at 64 bits then truncated.
module imm_gen_core
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]           i_instr,
  input  logic [IMM_TYPE_W-1:0] i_type,
  output logic [XLEN-1:0]       o_imm
);

  logic        w_s;
  logic [63:0] w_b;
  logic [63:0] w_i;
  logic [63:0] w_st;
  logic [63:0] w_u;
  logic [63:0] w_j;
  logic [63:0] w_z;
  logic [63:0] w_sh;
  logic [63:0] w_or;
  logic        w_sh5;
  logic        w_unused;

  assign w_s = i_instr[F_SIGN];

  assign w_b = {{51{w_s}}, w_s, i_instr[7],
                i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_i = {{52{w_s}}, i_instr[31:20]};
  assign w_st = {{52{w_s}}, i_instr[31:25],
                 i_instr[11:7]};
  assign w_u = {{32{w_s}}, i_instr[31:12], 12'b0};
  assign w_j = {{43{w_s}}, w_s, i_instr[19:12],
                i_instr[20], i_instr[30:21], 1'b0};
  assign w_z = {59'b0, i_instr[F_RS1_H:F_RS1_L]};

  // shamt bit 5 only exists in RV64
  assign w_sh5 = (XLEN == 64) ? i_instr[25] : 1'b0;
  assign w_sh  = {58'b0, w_sh5, i_instr[24:20]};

  assign w_or = ({64{i_type[T_B]}}  & w_b)
              | ({64{i_type[T_I]}}  & w_i)
              | ({64{i_type[T_S]}}  & w_st)
              | ({64{i_type[T_U]}}  & w_u)
              | ({64{i_type[T_J]}}  & w_j)
              | ({64{i_type[T_Z]}}  & w_z)
              | ({64{i_type[T_SH]}} & w_sh);

  assign o_imm = w_or[XLEN-1:0];

  assign w_unused = ^{i_instr[6:0], w_or};

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage with 2-entry skid buffer.
// IMM_GEN_ONEHOT_CHK_EN enables the one-hot type check.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [IMM_TYPE_W-1:0] in_type,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_target,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  tgt;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  logic [XLEN-1:0] w_imm;
  logic            w_err;
  logic            w_acc;
  logic            w_cons;
  ent_t            w_ent;

  skid_st_e r_st;
  ent_t     r_m;
  ent_t     r_k;
  logic     r_vld;
  logic     r_rdy;

  imm_gen_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_instr (in_instr),
    .i_type  (in_type),
    .o_imm   (w_imm)
  );

`ifdef IMM_GEN_ONEHOT_CHK_EN
  logic r_err_seen;

  assign w_err = ($countones(in_type) != 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_seen <= 1'b0;
    end else if (w_acc && w_err) begin
      r_err_seen <= 1'b1;
    end
  end
`else
  assign w_err = 1'b0;
`endif

  assign w_ent.imm = w_imm;
  assign w_ent.tgt = in_pc + w_imm;
  assign w_ent.tag = in_tag;
  assign w_ent.err = w_err;

  assign w_acc  = in_valid & r_rdy;
  assign w_cons = r_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= ST_EMPTY;
      r_m   <= '0;
      r_k   <= '0;
      r_vld <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      unique case (r_st)
        ST_EMPTY: begin
          if (w_acc) begin
            r_m   <= w_ent;
            r_vld <= 1'b1;
            r_st  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_cons) begin
            r_m <= w_ent;
          end else if (w_acc) begin
            r_k   <= w_ent;
            r_rdy <= 1'b0;
            r_st  <= ST_FULL;
          end else if (w_cons) begin
            r_vld <= 1'b0;
            r_st  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_cons) begin
            r_m   <= r_k;
            r_rdy <= 1'b1;
            r_st  <= ST_ONE;
          end
        end
        default: begin
          r_st  <= ST_EMPTY;
          r_vld <= 1'b0;
          r_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_rdy;
  assign out_valid  = r_vld;
  assign out_imm    = r_m.imm;
  assign out_target = r_m.tgt;
  assign out_tag    = r_m.tag;
  assign out_err    = r_m.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: vector table,
// back-pressure ordering, mid-operation reset, RV32 build.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [6:0]  in_type;
  logic [63:0] in_pc;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [63:0] out_target;
  logic [7:0]  out_tag;
  logic        out_err;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_instr;
  logic [6:0]  s_in_type;
  logic [31:0] s_in_pc;
  logic [7:0]  s_in_tag;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_imm;
  logic [31:0] s_out_target;
  logic [7:0]  s_out_tag;
  logic        s_out_err;

  int checks = 0;
  int errors = 0;

`ifdef IMM_GEN_ONEHOT_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [6:0] TB  = 7'b0000001;
  localparam logic [6:0] TI  = 7'b0000010;
  localparam logic [6:0] TS  = 7'b0000100;
  localparam logic [6:0] TU  = 7'b0001000;
  localparam logic [6:0] TJ  = 7'b0010000;
  localparam logic [6:0] TZ  = 7'b0100000;
  localparam logic [6:0] TSH = 7'b1000000;

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_type    (in_type),
    .in_pc      (in_pc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_target (out_target),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_instr   (s_in_instr),
    .in_type    (s_in_type),
    .in_pc      (s_in_pc),
    .in_tag     (s_in_tag),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_imm    (s_out_imm),
    .out_target (s_out_target),
    .out_tag    (s_out_tag),
    .out_err    (s_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  typ;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } vec_t;

  vec_t v[11];
  int   got[$];
  int   next_tag;
  logic acc;

  initial begin
    v[0]  = '{TI, 32'hFFF00093, 64'h0,
              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    v[1]  = '{TB, 32'hFE000EE3, 64'h80000010,
              64'hFFFFFFFFFFFFFFFC, 64'h000000008000000C, 1'b0};
    v[2]  = '{TU, 32'h800000B7, 64'h1000,
              64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1'b0};
    v[3]  = '{TJ, 32'h0010006F, 64'h100,
              64'h800, 64'h900, 1'b0};
    v[4]  = '{TZ, 32'h000F8073, 64'h0,
              64'h1F, 64'h1F, 1'b0};
    v[5]  = '{TSH, 32'h03F09093, 64'h40,
              64'd63, 64'h7F, 1'b0};
    v[6]  = '{TS, 32'hFE000E23, 64'h200,
              64'hFFFFFFFFFFFFFFFC, 64'h1FC, 1'b0};
    v[7]  = '{7'b0, 32'hFFFFFFFF, 64'h1234,
              64'h0, 64'h1234, EXP_ERR};
    v[8]  = '{TI | TB, 32'h00100093, 64'h0,
              64'h801, 64'h801, EXP_ERR};
    v[9]  = '{TJ, 32'h0010006F, 64'hFFFFFFFFFFFFFFFF,
              64'h800, 64'h7FF, 1'b0};
    v[10] = '{TB, 32'h7E000FE3, 64'h0,
              64'hFFE, 64'hFFE, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_type = '0;
    in_pc = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_instr = '0; s_in_type = '0;
    s_in_pc = '0; s_in_tag = '0; s_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_target", out_target, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);

    for (int n = 0; n < 11; n++) begin
      chk($sformatf("v%0d_in_ready", n), 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_instr = v[n].instr;
      in_type  = v[n].typ;
      in_pc    = v[n].pc;
      in_tag   = 8'(n + 16);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", n), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm", n), out_imm, v[n].imm);
      chk($sformatf("v%0d_tgt", n), out_target, v[n].tgt);
      chk($sformatf("v%0d_tag", n), 64'(out_tag), 64'(n + 16));
      chk($sformatf("v%0d_err", n), 64'(out_err), 64'(v[n].err));
    end
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // back-pressure: tags 1..5, out_ready low for the first cycles
    out_ready = 1'b0;
    next_tag = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 4) out_ready = 1'b1;
      in_valid = (next_tag <= 5);
      in_instr = {12'(next_tag), 20'h00093};
      in_type  = TI;
      in_pc    = 64'h100;
      in_tag   = 8'(next_tag);
      if (cyc == 2) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepts", 64'(next_tag - 1), 64'd2);
      end
      if (cyc >= 1 && cyc <= 3) begin
        chk($sformatf("stall%0d_valid", cyc), 64'(out_valid), 64'd1);
        chk($sformatf("stall%0d_tag", cyc), 64'(out_tag), 64'd1);
        chk($sformatf("stall%0d_imm", cyc), out_imm, 64'd1);
        chk($sformatf("stall%0d_tgt", cyc), out_target, 64'h101);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(int'(out_tag));
      @(posedge clk);
      if (acc) next_tag++;
      @(negedge clk);
      if (got.size() >= 5) break;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i + 1));
    repeat (2) @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // fill to FULL, then reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_type = TI;
    in_pc = 64'h10; in_tag = 8'hA1;
    @(negedge clk);
    in_tag = 8'hA2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_tag", 64'(out_tag), 64'hA1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_imm", out_imm, 64'd0);
    chk("mrst_target", out_target, 64'd0);
    chk("mrst_tag", 64'(out_tag), 64'd0);
    chk("mrst_err", 64'(out_err), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_no_ghost", 64'(out_valid), 64'd0);

    // RV32 build: U and SH
    s_in_valid = 1'b1; s_in_instr = 32'h800000B7;
    s_in_type = TU; s_in_pc = 32'hFFFFF000; s_in_tag = 8'h33;
    @(negedge clk);
    s_in_instr = 32'h03F09093; s_in_type = TSH;
    s_in_pc = 32'h0; s_in_tag = 8'h34;
    chk("rv32_u_imm", 64'(s_out_imm), 64'h80000000);
    chk("rv32_u_tgt", 64'(s_out_target), 64'h7FFFF000);
    chk("rv32_u_tag", 64'(s_out_tag), 64'h33);
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("rv32_sh_imm", 64'(s_out_imm), 64'd31);
    chk("rv32_sh_valid", 64'(s_out_valid), 64'd1);
    chk("rv32_err", 64'(s_out_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
